// File: rtl/alu_seq_ctrl.sv
// ALU operation sequencer: decodes ALUop/funct into a registered operation code
// and holds the block busy for the fixed latency of multiply and divide.
module alu_seq_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       ALUop,
  input  logic [3:0]       funct,
  input  logic             flush,
  output logic             in_ready,
  output logic [3:0]       operation,
  output logic             op_valid,
  output logic             busy,
  output logic             op_done,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             opv_q, opv_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;

  logic [3:0] dec_op;
  logic       dec_legal, dec_mul, dec_div;
  logic       accept;

  always_comb begin
    dec_op    = 4'b0000;
    dec_legal = 1'b1;
    dec_mul   = 1'b0;
    dec_div   = 1'b0;
    unique case (ALUop)
      2'b11: begin
        unique case (funct)
          4'b0000: dec_op = 4'b0001;
          4'b0001: dec_op = 4'b0010;
          4'b0100: begin dec_op = 4'b0011; dec_mul = 1'b1; end
          4'b0101: begin dec_op = 4'b0100; dec_div = 1'b1; end
          4'b0111: dec_op = 4'b0101;
          4'b1000: dec_op = 4'b0110;
          4'b1001: dec_op = 4'b0111;
          4'b1010: dec_op = 4'b1000;
          default: dec_legal = 1'b0;
        endcase
      end
      2'b10:   dec_op = 4'b0001;
      2'b01:   dec_op = 4'b1001;
      default: dec_op = 4'b0000;
    endcase
  end

  // flush wins over a same-cycle request, so a flushed request is simply dropped
  assign accept = in_valid && (state_q == IDLE) && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opv_d   = 1'b0;
    ill_d   = 1'b0;
    icnt_d  = icnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = dec_op;
          opv_d = 1'b1;
          if (!dec_legal) begin
            ill_d = 1'b1;
            if (icnt_q != {CNT_W{1'b1}}) icnt_d = icnt_q + CNT_W'(1);
          end
          if (dec_mul) begin
            state_d = EXEC;
            cnt_d   = 8'(MUL_CYCLES - 1);
          end else if (dec_div) begin
            state_d = EXEC;
            cnt_d   = 8'(DIV_CYCLES - 1);
          end
        end
      end
      EXEC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          op_d    = 4'b0000;
        end else if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      op_q    <= 4'b0000;
      opv_q   <= 1'b0;
      ill_q   <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opv_q   <= opv_d;
      ill_q   <= ill_d;
      icnt_q  <= icnt_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == EXEC);
  // an abort (flush or reset) on the last busy cycle suppresses completion
  assign op_done     = busy && (cnt_q == 8'd0) && !flush && !reset;
  assign operation   = op_q;
  assign op_valid    = opv_q;
  assign illegal     = ill_q;
  assign illegal_cnt = icnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed scenarios then random traffic, all checked
// cycle by cycle against a latency-count reference model.
module tb_alu_seq_ctrl;
  localparam int MULC = 4;
  localparam int DIVC = 8;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          reset, in_valid, flush;
  logic [1:0]    ALUop;
  logic [3:0]    funct;
  logic          in_ready, op_valid, busy, op_done, illegal;
  logic [3:0]    operation;
  logic [CW-1:0] illegal_cnt;

  int n_chk = 0;
  int n_err = 0;

  // reference model: registered outputs plus remaining busy cycles
  int m_op, m_opv, m_ill, m_cnt, m_left;

  alu_seq_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUop(ALUop), .funct(funct),
    .flush(flush), .in_ready(in_ready), .operation(operation), .op_valid(op_valid),
    .busy(busy), .op_done(op_done), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // returns op code, legality and busy length (0 = single-cycle op)
  task automatic ref_dec(input int a, input int f, output int op, output int legal, output int cyc);
    op = 0; legal = 1; cyc = 0;
    if (a == 3) begin
      case (f)
        0: op = 1;
        1: op = 2;
        4: begin op = 3; cyc = MULC; end
        5: begin op = 4; cyc = DIVC; end
        7: op = 5;
        8: op = 6;
        9: op = 7;
        10: op = 8;
        default: legal = 0;
      endcase
    end else if (a == 2) op = 1;
    else if (a == 1) op = 9;
  endtask

  task automatic cyc(input bit rst, input bit v, input int a, input int f, input bit fl);
    int op, legal, n;
    reset = rst; in_valid = v; ALUop = 2'(a); funct = 4'(f); flush = fl;
    #1;
    chk("in_ready", in_ready, m_left == 0);
    chk("busy", busy, m_left > 0);
    chk("op_done", op_done, (m_left == 1) && !fl && !rst);
    chk("operation", operation, m_op);
    chk("op_valid", op_valid, m_opv);
    chk("illegal", illegal, m_ill);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    if (rst) begin
      m_op = 0; m_opv = 0; m_ill = 0; m_cnt = 0; m_left = 0;
    end else begin
      m_opv = 0; m_ill = 0;
      if (m_left > 0) begin
        if (fl) begin m_left = 0; m_op = 0; end
        else m_left--;
      end else if (v && !fl) begin
        ref_dec(a, f, op, legal, n);
        m_op = op; m_opv = 1; m_left = n;
        if (!legal) begin
          m_ill = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ALUop = 2'b00; funct = 4'h0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    m_op = 0; m_opv = 0; m_ill = 0; m_cnt = 0; m_left = 0;

    // back-to-back single-cycle R-type ops
    cyc(0, 1, 3, 0, 0); cyc(0, 1, 3, 1, 0); cyc(0, 1, 3, 9, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    // multiply with in_valid held high during busy
    cyc(0, 1, 3, 4, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // divide flushed on its third busy cycle
    cyc(0, 1, 3, 5, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    // illegal funct saturation
    for (int i = 0; i < 5; i++) cyc(0, 1, 3, 15, 0);
    cyc(0, 0, 0, 0, 0);
    // non-R classes ignore funct
    cyc(0, 1, 2, 15, 0); cyc(0, 1, 1, 15, 0); cyc(0, 1, 0, 15, 0); cyc(0, 0, 0, 0, 0);
    // flush in IDLE drops a request
    cyc(0, 1, 3, 15, 1); cyc(0, 0, 0, 0, 0);
    // reset in the second busy cycle of multiply
    cyc(0, 1, 3, 4, 0); cyc(0, 0, 0, 0, 0); cyc(1, 1, 3, 4, 1);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      int a, f, pick;
      a = $urandom_range(0, 3);
      pick = $urandom_range(0, 9);
      f = (pick < 3) ? ((pick == 0) ? 4 : 5) : $urandom_range(0, 15);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, a, f,
          $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
